// File: rtl/mem_line_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory line arbiter.
//   arb_state_e  : arbiter FSM states (IDLE -> BURST -> DONE -> IDLE)
//   owner_e      : which cache miss path owns the current burst
//   LINE_OFF_BITS: byte-offset bits inside one cache line (4 x 16-bit words)
//   WORD_IDX_BITS: width of the word index within a line
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int LINE_OFF_BITS = 3;
    localparam int WORD_IDX_BITS = 2;

endpackage

// File: rtl/mem_line_arbiter_if.sv
// mem_line_arbiter_if: bundles the I-cache, D-cache and memory-side signals of
// the line arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives responses/mem_*)
//   master : environment view (caches + memory)
// Handshake: a cache raises *_req with a stable line address (and d_wr) and
// holds it until it observes its one-cycle *_done pulse; it drops the request
// on the clock edge that ends the done cycle. Read words are delivered with
// *_rvalid and the word index on *_word; write words are pulled combinationally
// through d_wdata indexed by d_word.
interface mem_line_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    import mem_arb_pkg::*;

    logic                     i_req;
    logic [ADDR_WIDTH-1:0]    i_addr;
    logic [15:0]              i_rdata;
    logic                     i_rvalid;
    logic [WORD_IDX_BITS-1:0] i_word;
    logic                     i_done;

    logic                     d_req;
    logic                     d_wr;
    logic [ADDR_WIDTH-1:0]    d_addr;
    logic [15:0]              d_wdata;
    logic [15:0]              d_rdata;
    logic                     d_rvalid;
    logic [WORD_IDX_BITS-1:0] d_word;
    logic                     d_done;

    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [15:0]              mem_wdata;
    logic                     mem_en;
    logic                     mem_wr;
    logic [15:0]              mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_rvalid, i_word, i_done,
        output d_rdata, d_rvalid, d_word, d_done,
        output mem_addr, mem_wdata, mem_en, mem_wr
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_rvalid, i_word, i_done,
        input  d_rdata, d_rvalid, d_word, d_done,
        input  mem_addr, mem_wdata, mem_en, mem_wr
    );

endinterface

// File: rtl/mem_line_arbiter_rr2.sv
// mem_arb_rr2: two-way round-robin picker between the I and D miss paths.
//   i_req, d_req : pending requests
//   last_owner   : owner of the most recently completed line
//   gnt_valid    : at least one request pending
//   gnt_owner    : chosen owner (the one that did not go last on a tie)
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_owner,
    output logic   gnt_valid,
    output owner_e gnt_owner
);

    always_comb begin
        gnt_valid = i_req | d_req;
        gnt_owner = OWN_I;
        if (i_req && d_req) begin
            gnt_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            gnt_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one single-port 16-bit byte-addressed memory between
// the I-cache (line reads) and D-cache (line fills / write-backs) miss paths.
// Each grant moves one 4-word line as a burst of word accesses, then pulses the
// owner's done for one cycle.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : mem_line_arbiter_if.slave (cache requests/responses, memory port)
//   busy      : FSM is not IDLE
//   dbg_state : current FSM state
// Parameters: ADDR_WIDTH (byte address width), WORDS_PER_LINE (words per line),
// ACCESS_CYCLES (cycles mem_en is held per word, >= 1).
module mem_line_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ACCESS_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_line_arbiter_if.slave bus,
    output logic              busy,
    output arb_state_e        dbg_state
);

    localparam int ACC_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0]    LINE_MASK = ~ADDR_WIDTH'((1 << LINE_OFF_BITS) - 1);
    localparam logic [WORD_IDX_BITS-1:0] LAST_WORD = WORD_IDX_BITS'(WORDS_PER_LINE - 1);
    localparam logic [ACC_W-1:0]         LAST_ACC  = ACC_W'(ACCESS_CYCLES - 1);

    arb_state_e               state_q, state_d;
    owner_e                   owner_q, owner_d;
    owner_e                   last_owner_q, last_owner_d;
    logic                     is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [WORD_IDX_BITS-1:0] word_q, word_d;
    logic [ACC_W-1:0]         acc_q, acc_d;

    logic                     gnt_valid;
    owner_e                   gnt_owner;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic                     last_acc;

    mem_arb_rr2 u_rr2 (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last_owner (last_owner_q),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            is_wr_q      <= 1'b0;
            base_q       <= '0;
            word_q       <= '0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            is_wr_q      <= is_wr_d;
            base_q       <= base_d;
            word_q       <= word_d;
            acc_q        <= acc_d;
        end
    end

    assign last_acc  = (acc_q == LAST_ACC);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // Every response and memory output below depends only on registered state
    // (plus the mem_rdata / d_wdata data passthroughs), so a request can never
    // reach mem_en combinationally.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        is_wr_d      = is_wr_q;
        base_d       = base_q;
        word_d       = word_q;
        acc_d        = acc_q;

        sel_addr     = (gnt_owner == OWN_D) ? bus.d_addr : bus.i_addr;

        bus.i_rdata  = '0;
        bus.i_rvalid = 1'b0;
        bus.i_word   = '0;
        bus.i_done   = 1'b0;
        bus.d_rdata  = '0;
        bus.d_rvalid = 1'b0;
        bus.d_word   = '0;
        bus.d_done   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = BURST;
                    owner_d = gnt_owner;
                    base_d  = sel_addr & LINE_MASK;
                    is_wr_d = bus.d_wr & (gnt_owner == OWN_D);
                    word_d  = '0;
                    acc_d   = '0;
                end
            end

            BURST: begin
                bus.mem_en = 1'b1;
                // base is line aligned, so OR-ing in the word offset never
                // carries out of the line.
                bus.mem_addr = base_q | ADDR_WIDTH'({word_q, 1'b0});
                if (owner_q == OWN_I) begin
                    bus.i_word = word_q;
                end else begin
                    bus.d_word = word_q;
                end

                if (last_acc) begin
                    if (is_wr_q) begin
                        bus.mem_wr    = 1'b1;
                        bus.mem_wdata = bus.d_wdata;
                    end else if (owner_q == OWN_I) begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.mem_rdata;
                    end else begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.mem_rdata;
                    end
                    acc_d = '0;
                    if (word_q == LAST_WORD) begin
                        state_d = DONE;
                        word_d  = '0;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end else begin
                    acc_d = acc_q + 1'b1;
                end
            end

            DONE: begin
                if (owner_q == OWN_I) begin
                    bus.i_done = 1'b1;
                end else begin
                    bus.d_done = 1'b1;
                end
                last_owner_d = owner_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: self-checking bench for mem_line_arbiter. Two DUTs share
// clk/rst: u_dut (ACCESS_CYCLES=1) and u_dut3 (ACCESS_CYCLES=3), each with its
// own memory model. A reference memory gives expected read data; expected
// read words and memory writes are queued when a request is issued and popped
// when the DUT produces them.
module tb_mem_line_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy, busy3;
    arb_state_e st, st3;

    always #5 clk = ~clk;

    mem_line_arbiter_if #(.ADDR_WIDTH(AW)) m  ();
    mem_line_arbiter_if #(.ADDR_WIDTH(AW)) m3 ();

    mem_line_arbiter #(.ADDR_WIDTH(AW), .WORDS_PER_LINE(4), .ACCESS_CYCLES(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (m),
        .busy      (busy),
        .dbg_state (st)
    );

    mem_line_arbiter #(.ADDR_WIDTH(AW), .WORDS_PER_LINE(4), .ACCESS_CYCLES(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .bus       (m3),
        .busy      (busy3),
        .dbg_state (st3)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_i_q[$];
    logic [15:0] exp_d_q[$];
    logic [15:0] exp_wa_q[$];
    logic [15:0] exp_wd_q[$];
    logic [15:0] ref_mem [0:32767];
    logic [15:0] mem     [0:32767];
    logic [15:0] mem3    [0:32767];
    logic [15:0] d_line  [4];
    logic        pre_we;
    logic [14:0] pre_idx;
    logic [15:0] pre_data;
    owner_e      tb_last;
    logic        i_fin, d_fin;

    // memory models: combinational read, write on the clock edge
    assign m.mem_rdata  = mem[m.mem_addr[15:1]];
    assign m3.mem_rdata = mem3[m3.mem_addr[15:1]];
    assign m.d_wdata    = d_line[m.d_word];
    assign m3.d_wdata   = 16'h0000;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx]  <= pre_data;
            mem3[pre_idx] <= pre_data;
        end else begin
            if (m.mem_en && m.mem_wr) mem[m.mem_addr[15:1]] <= m.mem_wdata;
            if (m3.mem_en && m3.mem_wr) mem3[m3.mem_addr[15:1]] <= m3.mem_wdata;
        end
    end

    // ---------------- clock/reset + driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] addr, input logic [15:0] data);
        pre_we   = 1'b1;
        pre_idx  = addr[15:1];
        pre_data = data;
        ref_mem[addr[15:1]] = data;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic clear_inputs();
        m.i_req = 1'b0;  m.i_addr = '0;
        m.d_req = 1'b0;  m.d_wr = 1'b0;  m.d_addr = '0;
        m3.i_req = 1'b0; m3.i_addr = '0;
        m3.d_req = 1'b0; m3.d_wr = 1'b0; m3.d_addr = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tb_last = OWN_I;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || st !== IDLE || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b state=%0d busy3=%b, required 0/IDLE/0", busy, st, busy3);
        end
        checks++;
        if (m.mem_en !== 1'b0 || m.mem_wr !== 1'b0 || m.mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem: en=%b wr=%b addr=%h, required 0/0/0000", m.mem_en, m.mem_wr, m.mem_addr);
        end
        checks++;
        if (m.i_rvalid !== 1'b0 || m.d_rvalid !== 1'b0 || m.i_done !== 1'b0 || m.d_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: i_rv=%b d_rv=%b i_done=%b d_done=%b, required all 0",
                     m.i_rvalid, m.d_rvalid, m.i_done, m.d_done);
        end
        tick();
        rst = 1'b0;
        tb_last = OWN_I;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b mem_en=%b, required 0/0", busy, m.mem_en);
        end
        tick();
    endtask

    // I-cache line read on u_dut, expected data from the reference memory.
    task automatic check_i_line(input logic [15:0] addr, input string tag);
        logic [15:0] base, e;
        base = addr & 16'hFFF8;
        for (int w = 0; w < 4; w++) exp_i_q.push_back(ref_mem[int'(base[15:1]) + w]);
        m.i_req  = 1'b1;
        m.i_addr = addr;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (k >= 1 && k <= 4) begin
                if (m.i_rvalid !== 1'b1 || m.i_word !== 2'(k - 1) || m.mem_addr !== base + 16'(2 * (k - 1)) ||
                    m.mem_wr !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_word k=%0d: rvalid=%b word=%0d addr=%h wr=%b busy=%b, required 1/%0d/%h/0/1",
                             tag, k, m.i_rvalid, m.i_word, m.mem_addr, m.mem_wr, busy, k - 1, base + 16'(2 * (k - 1)));
                end
                checks++;
                if (exp_i_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_data k=%0d: got %h, required nothing queued", tag, k, m.i_rdata);
                end else begin
                    e = exp_i_q.pop_front();
                    if (m.i_rdata !== e) begin
                        errors++;
                        $display("FAIL %s_data k=%0d: got %h, required %h", tag, k, m.i_rdata, e);
                    end
                end
            end else if (m.i_rvalid !== 1'b0 || busy !== (k == 5)) begin
                errors++;
                $display("FAIL %s_idle k=%0d: rvalid=%b busy=%b, required 0/%0d", tag, k, m.i_rvalid, busy, k == 5);
            end
            checks++;
            if (m.i_done !== (k == 5) || m.d_done !== 1'b0 || m.d_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL %s_done k=%0d: i_done=%b d_done=%b d_rv=%b, required %0d/0/0",
                         tag, k, m.i_done, m.d_done, m.d_rvalid, k == 5);
            end
            tick();
            if (k == 5) m.i_req = 1'b0;
        end
    endtask

    // D-cache write-back of d_line on u_dut.
    task automatic do_d_write_line(input logic [15:0] addr, input string tag);
        logic [15:0] base, ea, ed;
        base = addr & 16'hFFF8;
        for (int w = 0; w < 4; w++) begin
            ref_mem[int'(base[15:1]) + w] = d_line[w];
            exp_wa_q.push_back(base + 16'(2 * w));
            exp_wd_q.push_back(d_line[w]);
        end
        m.d_req  = 1'b1;
        m.d_wr   = 1'b1;
        m.d_addr = addr;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (k >= 1 && k <= 4) begin
                if (m.mem_wr !== 1'b1 || m.mem_en !== 1'b1 || m.d_word !== 2'(k - 1) ||
                    m.d_rvalid !== 1'b0 || m.i_rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_wr k=%0d: wr=%b en=%b word=%0d d_rv=%b i_rv=%b, required 1/1/%0d/0/0",
                             tag, k, m.mem_wr, m.mem_en, m.d_word, m.d_rvalid, m.i_rvalid, k - 1);
                end
                checks++;
                if (exp_wa_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_wdata k=%0d: write %h, required nothing queued", tag, k, m.mem_addr);
                end else begin
                    ea = exp_wa_q.pop_front();
                    ed = exp_wd_q.pop_front();
                    if (m.mem_addr !== ea || m.mem_wdata !== ed) begin
                        errors++;
                        $display("FAIL %s_wdata k=%0d: addr=%h data=%h, required %h/%h",
                                 tag, k, m.mem_addr, m.mem_wdata, ea, ed);
                    end
                end
            end else if (m.mem_wr !== 1'b0 || m.mem_en !== 1'b0) begin
                errors++;
                $display("FAIL %s_idle k=%0d: wr=%b en=%b, required 0/0", tag, k, m.mem_wr, m.mem_en);
            end
            checks++;
            if (m.d_done !== (k == 5) || m.i_done !== 1'b0) begin
                errors++;
                $display("FAIL %s_done k=%0d: d_done=%b i_done=%b, required %0d/0", tag, k, m.d_done, m.i_done, k == 5);
            end
            tick();
            if (k == 5) begin
                m.d_req = 1'b0;
                m.d_wr  = 1'b0;
            end
        end
    endtask

    task automatic test_i_read();
        check_i_line(16'h1004, "i_read");
    endtask

    task automatic test_d_write();
        d_line[0] = 16'hB0B0; d_line[1] = 16'hB1B1; d_line[2] = 16'hB2B2; d_line[3] = 16'hB3B3;
        do_d_write_line(16'h2000, "d_write");
        check_i_line(16'h2000, "readback");
    endtask

    task automatic test_tie();
        int          d_k[$];
        int          i_k[$];
        logic [15:0] e;
        logic        dd, id;
        apply_reset();
        for (int w = 0; w < 4; w++) exp_d_q.push_back(ref_mem[32'h1000 + w]);
        for (int w = 0; w < 4; w++) exp_i_q.push_back(ref_mem[32'h0800 + w]);
        m.i_req = 1'b1; m.i_addr = 16'h1000;
        m.d_req = 1'b1; m.d_wr = 1'b0; m.d_addr = 16'h2000;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (m.i_rvalid === 1'b1) begin
                checks++;
                e = (exp_i_q.size() != 0) ? exp_i_q.pop_front() : 16'hxxxx;
                if (m.i_rdata !== e) begin
                    errors++;
                    $display("FAIL tie_i_data k=%0d: got %h, required %h", k, m.i_rdata, e);
                end
            end
            if (m.d_rvalid === 1'b1) begin
                checks++;
                e = (exp_d_q.size() != 0) ? exp_d_q.pop_front() : 16'hxxxx;
                if (m.d_rdata !== e) begin
                    errors++;
                    $display("FAIL tie_d_data k=%0d: got %h, required %h", k, m.d_rdata, e);
                end
            end
            dd = (m.d_done === 1'b1);
            id = (m.i_done === 1'b1);
            if (dd) d_k.push_back(k);
            if (id) i_k.push_back(k);
            tick();
            if (dd) m.d_req = 1'b0;
            if (id) begin
                m.i_req = 1'b0;
                if (i_k.size() == 1) begin
                    for (int w = 0; w < 4; w++) exp_d_q.push_back(ref_mem[32'h1000 + w]);
                    for (int w = 0; w < 4; w++) exp_i_q.push_back(ref_mem[32'h0800 + w]);
                    m.i_req = 1'b1;
                    m.d_req = 1'b1;
                end
            end
        end
        checks++;
        if (d_k.size() != 2) begin
            errors++;
            $display("FAIL tie_d_order: %0d d_done pulses, required 2 at k=5,17", d_k.size());
        end else if (d_k[0] != 5 || d_k[1] != 17) begin
            errors++;
            $display("FAIL tie_d_order: d_done at k=%0d,%0d, required 5,17", d_k[0], d_k[1]);
        end
        checks++;
        if (i_k.size() != 2) begin
            errors++;
            $display("FAIL tie_i_order: %0d i_done pulses, required 2 at k=11,23", i_k.size());
        end else if (i_k[0] != 11 || i_k[1] != 23) begin
            errors++;
            $display("FAIL tie_i_order: i_done at k=%0d,%0d, required 11,23", i_k[0], i_k[1]);
        end
        checks++;
        if (exp_i_q.size() != 0 || exp_d_q.size() != 0) begin
            errors++;
            $display("FAIL tie_leftover: i=%0d d=%0d words undelivered, required 0/0", exp_i_q.size(), exp_d_q.size());
        end
        exp_i_q.delete();
        exp_d_q.delete();
    endtask

    task automatic test_slow_fill();
        logic [15:0] e;
        int          widx;
        logic        rv;
        for (int w = 0; w < 4; w++) exp_d_q.push_back(ref_mem[32'h1800 + w]);
        m3.d_req = 1'b1; m3.d_wr = 1'b0; m3.d_addr = 16'h3000;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            widx = (k - 1) / 3;
            rv   = (k >= 1 && k <= 12 && (k % 3) == 0);
            checks++;
            if (k >= 1 && k <= 12) begin
                if (m3.mem_en !== 1'b1 || m3.mem_addr !== 16'h3000 + 16'(2 * widx) || m3.d_rvalid !== rv ||
                    m3.mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL slow_acc k=%0d: en=%b addr=%h rv=%b wr=%b, required 1/%h/%0d/0",
                             k, m3.mem_en, m3.mem_addr, m3.d_rvalid, m3.mem_wr, 16'h3000 + 16'(2 * widx), rv);
                end
            end else if (m3.mem_en !== 1'b0 || m3.d_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL slow_idle k=%0d: en=%b rv=%b, required 0/0", k, m3.mem_en, m3.d_rvalid);
            end
            if (rv) begin
                checks++;
                e = (exp_d_q.size() != 0) ? exp_d_q.pop_front() : 16'hxxxx;
                if (m3.d_rdata !== e || m3.d_word !== 2'(widx)) begin
                    errors++;
                    $display("FAIL slow_data k=%0d: data=%h word=%0d, required %h/%0d", k, m3.d_rdata, m3.d_word, e, widx);
                end
            end
            checks++;
            if (m3.d_done !== (k == 13) || busy3 !== (k >= 1 && k <= 13)) begin
                errors++;
                $display("FAIL slow_done k=%0d: d_done=%b busy=%b, required %0d/%0d",
                         k, m3.d_done, busy3, k == 13, k >= 1 && k <= 13);
            end
            tick();
            if (k == 13) m3.d_req = 1'b0;
        end
        exp_d_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        d_line[0] = 16'hF000; d_line[1] = 16'hF111; d_line[2] = 16'hF222; d_line[3] = 16'hF333;
        m.d_req = 1'b1; m.d_wr = 1'b1; m.d_addr = 16'h4000;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1 || k == 2) begin
                checks++;
                if (m.mem_wr !== 1'b1 || m.mem_addr !== 16'h4000 + 16'(2 * (k - 1))) begin
                    errors++;
                    $display("FAIL rstmid_pre k=%0d: wr=%b addr=%h, required 1/%h", k, m.mem_wr, m.mem_addr,
                             16'h4000 + 16'(2 * (k - 1)));
                end
            end
            if (k >= 4) begin
                checks++;
                if (m.mem_wr !== 1'b0 || m.mem_en !== 1'b0 || m.d_done !== 1'b0 || busy !== 1'b0 || st !== IDLE) begin
                    errors++;
                    $display("FAIL rstmid_post k=%0d: wr=%b en=%b done=%b busy=%b state=%0d, required 0/0/0/0/IDLE",
                             k, m.mem_wr, m.mem_en, m.d_done, busy, st);
                end
            end
            tick();
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                rst = 1'b0;
                m.d_req = 1'b0;
                m.d_wr  = 1'b0;
                tb_last = OWN_I;
            end
        end
        d_line[0] = 16'h4A4A; d_line[1] = 16'h4B4B; d_line[2] = 16'h4C4C; d_line[3] = 16'h4D4D;
        do_d_write_line(16'h4000, "post_rst_wr");
        check_i_line(16'h4002, "post_rst_rd");
    endtask

    // ---------------- random traffic ----------------
    task automatic i_agent(input int n);
        logic [15:0] a, base;
        int          waited;
        for (int t = 0; t < n; t++) begin
            a    = 16'h5000 | 16'($urandom_range(0, 255));
            base = a & 16'hFFF8;
            for (int w = 0; w < 4; w++) exp_i_q.push_back(ref_mem[int'(base[15:1]) + w]);
            m.i_addr = a;
            m.i_req  = 1'b1;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (m.i_done !== 1'b1 && waited < 60);
            checks++;
            if (m.i_done !== 1'b1) begin
                errors++;
                $display("FAIL rnd_i_lost line=%0d: no i_done in %0d cycles, required done", t, waited);
            end
            tick();
            m.i_req = 1'b0;
            if (t >= 4) repeat ($urandom_range(0, 2)) tick();
        end
        i_fin = 1'b1;
    endtask

    task automatic d_agent(input int n);
        logic [15:0] a, base;
        logic        wr;
        int          waited;
        for (int t = 0; t < n; t++) begin
            a    = 16'h6000 | 16'($urandom_range(0, 255));
            base = a & 16'hFFF8;
            wr   = 1'($urandom_range(0, 1));
            for (int w = 0; w < 4; w++) begin
                if (wr) begin
                    d_line[w] = 16'($urandom_range(0, 65535));
                    ref_mem[int'(base[15:1]) + w] = d_line[w];
                    exp_wa_q.push_back(base + 16'(2 * w));
                    exp_wd_q.push_back(d_line[w]);
                end else begin
                    exp_d_q.push_back(ref_mem[int'(base[15:1]) + w]);
                end
            end
            m.d_addr = a;
            m.d_wr   = wr;
            m.d_req  = 1'b1;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (m.d_done !== 1'b1 && waited < 60);
            checks++;
            if (m.d_done !== 1'b1) begin
                errors++;
                $display("FAIL rnd_d_lost line=%0d: no d_done in %0d cycles, required done", t, waited);
            end
            tick();
            m.d_req = 1'b0;
            m.d_wr  = 1'b0;
            if (t >= 4) repeat ($urandom_range(0, 2)) tick();
        end
        d_fin = 1'b1;
    endtask

    task automatic rnd_monitor();
        int          cyc, ties;
        logic [15:0] e, ea;
        owner_e      o;
        logic        tie_pending;
        owner_e      tie_exp;
        cyc = 0;
        ties = 0;
        tie_pending = 1'b0;
        tie_exp = OWN_D;
        while (!(i_fin && d_fin) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (m.i_rvalid === 1'b1) begin
                checks++;
                e = (exp_i_q.size() != 0) ? exp_i_q.pop_front() : 16'hxxxx;
                if (m.i_rdata !== e || m.mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_i_data cyc=%0d: got %h wr=%b, required %h/0", cyc, m.i_rdata, m.mem_wr, e);
                end
            end
            if (m.d_rvalid === 1'b1) begin
                checks++;
                e = (exp_d_q.size() != 0) ? exp_d_q.pop_front() : 16'hxxxx;
                if (m.d_rdata !== e || m.mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_d_data cyc=%0d: got %h wr=%b, required %h/0", cyc, m.d_rdata, m.mem_wr, e);
                end
            end
            if (m.mem_wr === 1'b1) begin
                checks++;
                ea = (exp_wa_q.size() != 0) ? exp_wa_q.pop_front() : 16'hxxxx;
                e  = (exp_wd_q.size() != 0) ? exp_wd_q.pop_front() : 16'hxxxx;
                if (m.mem_addr !== ea || m.mem_wdata !== e) begin
                    errors++;
                    $display("FAIL rnd_write cyc=%0d: addr=%h data=%h, required %h/%h",
                             cyc, m.mem_addr, m.mem_wdata, ea, e);
                end
            end
            if (m.i_done === 1'b1 || m.d_done === 1'b1) begin
                o = (m.d_done === 1'b1) ? OWN_D : OWN_I;
                if (tie_pending) begin
                    checks++;
                    ties++;
                    if (o !== tie_exp) begin
                        errors++;
                        $display("FAIL rnd_rr cyc=%0d: tie went to owner %0d, required %0d", cyc, o, tie_exp);
                    end
                    tie_pending = 1'b0;
                end
                tb_last = o;
            end
            if (busy === 1'b0 && m.i_req === 1'b1 && m.d_req === 1'b1) begin
                tie_pending = 1'b1;
                tie_exp = (tb_last == OWN_I) ? OWN_D : OWN_I;
            end
        end
        checks++;
        if (!(i_fin && d_fin)) begin
            errors++;
            $display("FAIL rnd_timeout: i_fin=%b d_fin=%b after %0d cycles, required both finished", i_fin, d_fin, cyc);
        end
        checks++;
        if (ties == 0) begin
            errors++;
            $display("FAIL rnd_contention: %0d ties observed, required at least 1", ties);
        end
    endtask

    task automatic test_random();
        apply_reset();
        i_fin = 1'b0;
        d_fin = 1'b0;
        fork
            i_agent(14);
            d_agent(14);
            rnd_monitor();
        join
        repeat (2) tick();
        checks++;
        if (exp_i_q.size() != 0 || exp_d_q.size() != 0 || exp_wa_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_leftover: i=%0d d=%0d w=%0d pending, required 0/0/0",
                     exp_i_q.size(), exp_d_q.size(), exp_wa_q.size());
        end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        rst    = 1'b1;
        pre_we = 1'b0;
        pre_idx = '0;
        pre_data = '0;
        tb_last = OWN_I;
        i_fin = 1'b0;
        d_fin = 1'b0;
        for (int w = 0; w < 4; w++) d_line[w] = 16'h0000;
        clear_inputs();
        tick();
        preload(16'h1000, 16'hA0A0);
        preload(16'h1002, 16'hA1A1);
        preload(16'h1004, 16'hA2A2);
        preload(16'h1006, 16'hA3A3);
        preload(16'h3000, 16'hC0C0);
        preload(16'h3002, 16'hC1C1);
        preload(16'h3004, 16'hC2C2);
        preload(16'h3006, 16'hC3C3);
        for (int w = 0; w < 128; w++) preload(16'h5000 + 16'(2 * w), 16'($urandom_range(0, 65535)));
        for (int w = 0; w < 128; w++) preload(16'h6000 + 16'(2 * w), 16'($urandom_range(0, 65535)));

        test_reset();
        test_i_read();
        test_d_write();
        test_tie();
        test_slow_fill();
        test_reset_mid_burst();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
